// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. It synchronizes rx and detects the start-bit
//            falling edge. It checks the start bit at mid-bit, samples eight
//            data bits LSB first, and checks the stop bit. The received byte
//            goes to a one-entry valid/ready output register.
// Ports    : clk       - system clock, rising-edge active
//            rst       - asynchronous active-low reset
//            rx        - asynchronous serial line, idle high
//            data      - received byte, meaningful while valid=1
//            valid     - data holds an unconsumed byte
//            ready     - consumer accepts data (transfer on valid & ready)
//            busy      - receiver is inside a frame (state != IDLE)
//            frame_err - one-cycle pulse when the stop bit is sampled low
//            overrun   - one-cycle pulse when a good byte is dropped
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          stop_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      stop_bit  <= 1'b1;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      rx_d      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer handshake; a load in the same cycle below overrides this.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          // The stop bit is sampled at count FULL_M1. The result is acted on
          // one cycle later, and the block returns to IDLE at that point.
          if (cnt == FULL) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (!stop_bit) begin
              frame_err <= 1'b1;
            end else if (!valid || ready) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            if (cnt == FULL_M1) begin
              stop_bit <= rx_s;
            end
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with CLKS_PER_BIT=16. Frames are
//            driven on rx. A timeline model predicts valid, data, busy,
//            frame_err and overrun, and these are compared against the DUT
//            on every falling clock edge. Literal checks pin latency and
//            the key scenario results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;
  // Edge detection to valid: H + 9*CPB + 1 = 8 + 144 + 1.
  localparam int LAT = 153;
  // rx falls just before rising edge c+1. It passes two synchronizer flops,
  // and the FSM registers the edge at rising edge c+3.
  localparam int SYNC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct {
    int         t;
    logic [7:0] b;
    logic       ok;
  } ev_t;

  ev_t  evq[$];
  int   bfrom[$];
  int   bto[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_ovr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      evq.delete();
      bfrom.delete();
      bto.delete();
    end else begin
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (m_valid && ready) m_valid <= 1'b0;
      if (evq.size() != 0 && evq[0].t == cyc + 1) begin
        if (!evq[0].ok) begin
          m_ferr <= 1'b1;
        end else if (!m_valid || ready) begin
          m_valid <= 1'b1;
          m_data  <= evq[0].b;
        end else begin
          m_ovr <= 1'b1;
        end
        evq.delete(0);
      end
    end
  end

  function automatic logic exp_busy(input int n);
    foreach (bfrom[i]) if (n >= bfrom[i] && n < bto[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("data", {24'd0, data}, {24'd0, m_data});
    check("busy", {31'd0, busy}, {31'd0, exp_busy(cyc)});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  end

  // ---------------- event monitor for literal checks ----------------
  logic       pv = 1'b0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         nrise = 0;
  int         nferr = 0;
  int         novr = 0;
  logic [7:0] rq[$];

  always @(negedge clk) begin
    pv <= valid;
    if (valid && !pv) begin
      rise_cyc <= cyc;
      nrise    <= nrise + 1;
      rq.push_back(data);
    end
    if (!valid && pv) fall_cyc <= cyc;
    if (frame_err) nferr <= nferr + 1;
    if (overrun) novr <= novr + 1;
  end

  // ---------------- stimulus ----------------
  int last_fall = 0;

  // Call at a falling edge; returns at a falling edge so calls chain back-to-back.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] bits;
    int c;
    bits = {stop, b, 1'b0};
    c = cyc;
    last_fall = c;
    if (nbits == 10) begin
      evq.push_back('{t: c + SYNC + LAT, b: b, ok: stop});
      bfrom.push_back(c + SYNC);
      bto.push_back(c + SYNC + LAT);
    end else begin
      bfrom.push_back(c + SYNC);
      bto.push_back(32'h3fff_ffff);
    end
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (nbits == 10) rx = 1'b1;
  endtask

  task automatic drive_glitch();
    int c;
    c = cyc;
    // Start sample at c+3+8 sees the line high again: START for 8 cycles.
    bfrom.push_back(c + SYNC);
    bto.push_back(c + SYNC + CPB / 2);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
  endtask

  int base_r, base_f, base_o;

  task automatic snap();
    base_r = nrise;
    base_f = nferr;
    base_o = novr;
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame 0xA5: latency and one-cycle valid with ready=1.
    snap();
    drive_frame(8'hA5, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("a5_count", nrise - base_r, 32'd1);
    check("a5_latency", rise_cyc - last_fall - SYNC, 32'd153);
    check("a5_data", {24'd0, rq[rq.size()-1]}, 32'hA5);
    check("a5_width", fall_cyc - rise_cyc, 32'd1);

    // Back-to-back 0x00 then 0xFF.
    snap();
    drive_frame(8'h00, 1'b1, 10);
    drive_frame(8'hFF, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("b2b_count", nrise - base_r, 32'd2);
    check("b2b_data0", {24'd0, rq[rq.size()-2]}, 32'h00);
    check("b2b_data1", {24'd0, rq[rq.size()-1]}, 32'hFF);
    check("b2b_ferr", nferr - base_f, 32'd0);

    // 8-cycle glitch: rejected at the start sample.
    snap();
    drive_glitch();
    repeat (40) @(negedge clk);
    check("glitch_valid", nrise - base_r, 32'd0);
    check("glitch_flags", (nferr - base_f) + (novr - base_o), 32'd0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Bad stop bit on 0x3C, then good 0x5A after the line idles.
    snap();
    drive_frame(8'h3C, 1'b0, 10);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    drive_frame(8'h5A, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("ferr_count", nferr - base_f, 32'd1);
    check("ferr_rx_count", nrise - base_r, 32'd1);
    check("ferr_next_data", {24'd0, rq[rq.size()-1]}, 32'h5A);

    // Overrun: ready=0, 0x11 then 0x22.
    ready = 1'b0;
    snap();
    drive_frame(8'h11, 1'b1, 10);
    drive_frame(8'h22, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("ovr_count", novr - base_o, 32'd1);
    check("ovr_rises", nrise - base_r, 32'd1);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    check("ovr_data", {24'd0, data}, 32'h11);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_xfer", {31'd0, valid}, 32'd0);
    repeat (10) @(negedge clk);

    // Mid-frame reset: hold 0x77 (ready=0), then reset during bit 4 of a second 0x77.
    ready = 1'b0;
    drive_frame(8'h77, 1'b1, 10);
    drive_frame(8'h77, 1'b1, 5);
    rx = 1'b1;  // data bit 4 of 0x77
    repeat (8) @(negedge clk);
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_data", {24'd0, data}, 32'h00);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ready = 1'b1;
    snap();
    repeat (300) @(negedge clk);
    check("post_rst_quiet", (nrise - base_r) + (nferr - base_f) + (novr - base_o), 32'd0);
    drive_frame(8'h96, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("post_rst_count", nrise - base_r, 32'd1);
    check("post_rst_data", {24'd0, rq[rq.size()-1]}, 32'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 4..1023.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, asynchronous, active-low.
REQ-004 The block SHALL have port rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port data, output, 8 bits, the received byte, valid while valid=1.
REQ-006 The block SHALL have port valid, output, 1 bit, meaning data holds an unconsumed byte.
REQ-007 The block SHALL have port ready, input, 1 bit, meaning the consumer accepts data; a transfer occurs on any cycle with valid=1 and ready=1.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a completed byte is dropped.

Function
REQ-011 The block SHALL pass rx through a two-flop synchronizer (reset value 1); rx_s is its output; rx_d is rx_s delayed one cycle. All timing below is relative to rx_s.
REQ-012 The block SHALL implement states IDLE, START, DATA and STOP, with an internal cycle counter (width ceil(log2(CLKS_PER_BIT))+1) and a 3-bit bit index.
REQ-013 In IDLE, a falling edge (rx_d=1, rx_s=0) SHALL move the block to START and clear the counter; a low level without a preceding edge SHALL NOT start a frame.
REQ-014 In START, the block SHALL sample rx_s H=CLKS_PER_BIT/2 (integer division) cycles after edge detection; on 0 it SHALL go to DATA with counter=0 and index=0; on 1 it SHALL return to IDLE with no flag (glitch rejection).
REQ-015 In DATA, the block SHALL sample rx_s every CLKS_PER_BIT cycles, shifting the bits LSB first; after the 8th sample it SHALL go to STOP.
REQ-016 In STOP, the block SHALL sample rx_s CLKS_PER_BIT cycles after bit 7, then go to IDLE on the next cycle, so that back-to-back frames are accepted.
REQ-017 If the stop sample is 1 and (valid=0, or valid=1 with ready=1 in that cycle), data SHALL load the byte and valid SHALL be 1 on the next cycle.
REQ-018 If the stop sample is 1 and valid=1 with ready=0, overrun SHALL pulse for one cycle, while data and valid stay unchanged and the new byte is discarded.
REQ-019 If the stop sample is 0, frame_err SHALL pulse for one cycle, the byte SHALL be discarded, valid/data SHALL be unaffected, and the next frame requires a new falling edge.
REQ-020 On a transfer with no simultaneous load, valid SHALL be 0 on the next cycle.
REQ-021 data SHALL remain stable while valid=1 and ready=0.
REQ-022 Latency SHALL be exactly H+9*CLKS_PER_BIT+1 cycles from edge detection to valid rising.
REQ-023 ready SHALL have no effect while valid=0.

Reset
REQ-024 On rst=0 (at any time, including mid-frame), the block SHALL immediately force: state IDLE; counter and index 0; synchronizer flops and rx_d to 1; data=0x00; valid=0; busy=0; frame_err=0; overrun=0.
REQ-025 After rst rises, the block SHALL require a new falling edge before receiving; a partial frame SHALL never produce valid, frame_err or overrun.

Verification (CLKS_PER_BIT=16, ready=1 unless stated)
REQ-026 Drive frame 0xA5 with stop=1 -> valid rises 153 cycles after edge detection with data=0xA5; valid low on the next cycle.
REQ-027 Drive two back-to-back frames 0x00 then 0xFF -> two valid pulses, data 0x00 then 0xFF, frame_err=0.
REQ-028 Drive an 8-cycle low glitch on rx -> the block returns to IDLE after the start sample; busy falls; no valid and no flags.
REQ-029 Drive frame 0x3C with stop=0 -> frame_err pulses once; valid stays 0; the next good frame 0x5A is received correctly.
REQ-030 Hold ready=0 and drive frames 0x11 then 0x22 -> valid=1 with data=0x11 throughout; overrun pulses once at the second stop sample; raising ready transfers 0x11.
REQ-031 Assert rst=0 mid-frame at bit 4 of 0x77 -> all outputs go to their reset values immediately; after release, no valid is produced until a new frame arrives.
